// File: rtl/secure_scrub_fifo.sv
// secure_scrub_fifo: FWFT FIFO that zeroes freed slots and supports a timed full-scrub on request
module secure_scrub_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       zeroize,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {RUN, SCRUB} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, sidx;
    logic push, pop;
    assign busy      = state == SCRUB;
    assign in_ready  = (count != CW'(DEPTH)) && !busy && !zeroize;
    assign out_valid = (count != '0) && !busy;
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !zeroize;
    // controller state register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end
    // zeroize (re)starts a scrub; the scrub ends after the last entry is cleared
    always_comb begin
        state_nxt = state;
        state_nxt = zeroize ? SCRUB
                  : (state == SCRUB && sidx == AW'(DEPTH - 1)) ? RUN : state;
    end
    // storage: write on push, clear on pop, clear one entry per scrub cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == SCRUB) begin
            mem[sidx] <= '0;
        end else begin
            if (push) mem[wptr] <= in_data;
            if (pop)  mem[rptr] <= '0;
        end
    end
    // pointers, occupancy and scrub index
    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            sidx  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (state == SCRUB) sidx <= sidx + 1'b1;
        end
    end
endmodule

// File: tb/tb_secure_scrub_fifo.sv
// tb_secure_scrub_fifo: directed self-checking bench for secure_scrub_fifo (WIDTH=8, DEPTH=4)
module tb_secure_scrub_fifo;
    logic       clk = 0;
    logic       rst = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [7:0] out_data;
    logic       zeroize = 0;
    logic       busy;
    logic [2:0] count;
    int tests = 0;
    int fails = 0;

    secure_scrub_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .zeroize(zeroize), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        in_valid = 1; in_data = v;
        step();
        in_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); rst = 0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    endtask

    task automatic test_order();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push_word(v[i]);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got %0d exp 4", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_valid !== 1'b1 || out_data !== v[i]) begin fails++; $display("FAIL order_pop%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, v[i]); end
            step();
        end
        out_ready = 0;
        tests++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin fails++; $display("FAIL empty_after_pop got v=%b d=%h exp v=0 d=00", out_valid, out_data); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL empty_count got %0d exp 0", count); end
    endtask

    task automatic test_pop_scrub();
        push_word(8'hA5);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin fails++; $display("FAIL fwft_a5 got v=%b d=%h exp v=1 d=a5", out_valid, out_data); end
        out_ready = 1; step(); out_ready = 0;
        tests++; if (dut.mem[0] !== 8'h00) begin fails++; $display("FAIL freed_slot got %h exp 00", dut.mem[0]); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL out_after_pop got %h exp 00", out_data); end
    endtask

    task automatic test_zeroize();
        for (int i = 0; i < 4; i++) push_word(8'hFF);
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL ff_fill_count got %0d exp 4", count); end
        zeroize = 1; step(); zeroize = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL scrub_cycle%0d got busy=%b rdy=%b ov=%b cnt=%0d exp 1 0 0 0", i, busy, in_ready, out_valid, count); end
            step();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL scrub_end_busy got %b exp 0", busy); end
        tests++; if (count !== 3'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL scrub_end_state got cnt=%0d rdy=%b exp 0 1", count, in_ready); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (dut.mem[i] !== 8'h00) begin fails++; $display("FAIL scrub_mem%0d got %h exp 00", i, dut.mem[i]); end
        end
    endtask

    task automatic test_rezeroize();
        zeroize = 1; step(); zeroize = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rz_c1 got %b exp 1", busy); end
        step();
        zeroize = 1; step(); zeroize = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rz_ext%0d got %b exp 1", i, busy); end
            step();
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rz_end got %b exp 0", busy); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 3; i++) push_word(8'(i));
        out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            tests++; if (out_data !== 8'(i)) begin fails++; $display("FAIL pre_wrap%0d got %h exp %h", i, out_data, 8'(i)); end
            step();
        end
        out_ready = 0;
        push_word(8'hB1);
        push_word(8'hB2);
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL wrap_count got %0d exp 2", count); end
        in_valid = 1; in_data = 8'hB3; out_ready = 1;
        tests++; if (out_data !== 8'hB1) begin fails++; $display("FAIL wrap_b1 got %h exp b1", out_data); end
        step();
        in_valid = 0;
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL simul_count got %0d exp 2", count); end
        tests++; if (out_data !== 8'hB2) begin fails++; $display("FAIL wrap_b2 got %h exp b2", out_data); end
        step();
        tests++; if (out_data !== 8'hB3) begin fails++; $display("FAIL wrap_b3 got %h exp b3", out_data); end
        step();
        out_ready = 0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty got cnt=%0d ov=%b exp 0 0", count, out_valid); end
    endtask

    task automatic test_rst_scrub();
        push_word(8'h5A);
        zeroize = 1; step(); zeroize = 0;
        step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rs_mid_busy got %b exp 1", busy); end
        rst = 1; step(); rst = 0;
        tests++; if (busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL rs_state got busy=%b cnt=%0d rdy=%b exp 0 0 1", busy, count, in_ready); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (dut.mem[i] !== 8'h00) begin fails++; $display("FAIL rs_mem%0d got %h exp 00", i, dut.mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_pop_scrub();
        test_zeroize();
        test_rezeroize();
        test_wrap();
        test_rst_scrub();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/secure_scrub_fifo.md
SECURE_SCRUB_FIFO -- requirements
Module: secure_scrub_fifo

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 4, number of storage entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, producer has a word on in_data.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH, write data.
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds the oldest stored word.
REQ-009 The block SHALL have port out_ready, input, 1, consumer takes out_data this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH, read data.
REQ-011 The block SHALL have port zeroize, input, 1, request to discard and scrub all contents.
REQ-012 The block SHALL have port busy, output, 1, scrub in progress.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1, number of stored words.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH register array with wrapping read/write pointers; first-word-fall-through ordering, FIFO order preserved.
REQ-015 Push SHALL occur on a rising edge with in_valid && in_ready; in_ready SHALL equal (count != DEPTH) && !busy && !zeroize.
REQ-016 Pop SHALL occur on a rising edge with out_valid && out_ready; out_valid SHALL equal (count != 0) && !busy.
REQ-017 A popped entry SHALL be written to all-zeros on the same edge it is popped (no stale data left in freed slots).
REQ-018 out_data SHALL equal the entry at the read pointer when out_valid=1 and SHALL be all-zeros whenever out_valid=0.
REQ-019 A pushed word SHALL appear on out_data with out_valid=1 on the cycle after the push edge if the FIFO was empty; there is no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL both take effect, count unchanged; pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor go below 0.
REQ-022 The controller SHALL have two states: RUN and SCRUB.
REQ-023 In RUN, zeroize=1 at an edge SHALL set pointers and count to 0, scrub index to 0, and enter SCRUB; any push or pop in that cycle SHALL be ignored (zeroize has priority).
REQ-024 In SCRUB, busy SHALL be 1, and one entry (scrub index) SHALL be written to zero per cycle, index incrementing 0..DEPTH-1.
REQ-025 After the entry DEPTH-1 write, the state SHALL return to RUN; busy SHALL be high for exactly DEPTH cycles after the zeroize edge.
REQ-026 zeroize=1 during SCRUB SHALL restart the scrub index at 0, extending busy by a full DEPTH cycles from that edge.
REQ-027 In SCRUB, no push or pop SHALL occur and count SHALL remain 0.

Reset
REQ-028 On rst=1 at an edge, every storage entry SHALL clear to zero in that single cycle, pointers, count and scrub index SHALL go to 0, and state SHALL go to RUN.
REQ-029 After reset: in_ready=1, out_valid=0, out_data=0, busy=0, count=0.
REQ-030 rst SHALL take priority over zeroize, push and pop, including mid-SCRUB.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Push 0x11,0x22,0x33,0x44 -> count=4, in_ready=0; pops yield 0x11,0x22,0x33,0x44 in order, then out_valid=0, out_data=0x00.
REQ-032 Push 0xA5, pop it, then inspect the freed slot via hierarchical check -> 0x00; out_data=0x00 after pop.
REQ-033 Fill with 0xFF x4, assert zeroize 1 cycle -> busy=1 for 4 cycles, in_ready=0, out_valid=0, all entries 0x00 after, count=0.
REQ-034 Zeroize mid-SCRUB (cycle 2) -> busy remains high 4 cycles from the second zeroize edge.
REQ-035 Count=2, push and pop on same edge with wrap (pointers at 3) -> count stays 2, order preserved across wrap.
REQ-036 rst asserted mid-SCRUB with stored 0x5A -> next cycle busy=0, count=0, all entries 0x00, in_ready=1.
